// File: rtl/avr_cpu_fetch.sv
// avr_cpu_fetch: instruction fetch and sequencing for the AVR core.
// Drives the synchronous program memory, presents each opcode to the decoder
// together with its execute phase, and advances the program counter from the
// decoder's hold/jump/return requests and the execute stage's branch and skip
// decisions.
module avr_cpu_fetch #(
  parameter int                    PC_WIDTH     = 12,
  parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [PC_WIDTH-1:0] pmem_addr,
  input  logic [15:0]         pmem_data,
  output logic [15:0]         opcode,
  output logic                cycle,
  output logic [PC_WIDTH-1:0] pc,
  input  logic                hold,
  input  logic [15:0]         pc_update,
  input  logic                stack_read,
  input  logic                stack_write,
  output logic [PC_WIDTH-1:0] ret_addr,
  input  logic [PC_WIDTH-1:0] ret_data,
  input  logic                branch_taken,
  input  logic                skip
);

  // Sequencer states: BOOT primes the memory pipeline after reset, RUN
  // executes one instruction per cycle, SECOND replays a held instruction,
  // SKIP shows a NOP in place of the discarded word.
  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_SECOND = 2'd2;
  localparam logic [1:0] ST_SKIP   = 2'd3;

  localparam logic [PC_WIDTH-1:0] ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]          state;
  logic [1:0]          state_next;
  logic [PC_WIDTH-1:0] pc_next;
  logic [15:0]         ir;
  logic [15:0]         ir_next;
  logic [PC_WIDTH-1:0] target;
  logic [PC_WIDTH-1:0] target_next;

  logic [PC_WIDTH-1:0] pc1;
  logic [PC_WIDTH-1:0] off;
  logic [PC_WIDTH-1:0] rel_target;

  // stack_write only tells the stack to push ret_addr; upper offset bits
  // beyond the address width are meaningless after modulo arithmetic.
  logic unused_inputs;
  assign unused_inputs = ^{stack_write, pc_update};

  // Address arithmetic shared by all states; wrap-around is intentional.
  assign pc1        = pc + ONE;
  assign off        = pc_update[PC_WIDTH-1:0];
  assign rel_target = pc1 + off;
  assign ret_addr   = pc1;

  // Next-state, fetch address and decoder-facing outputs from the current state.
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    ir_next     = ir;
    target_next = target;
    pmem_addr   = pc1;
    opcode      = 16'h0000;
    cycle       = 1'b0;

    case (state)
      ST_BOOT: begin
        pmem_addr  = RESET_VECTOR;
        pc_next    = RESET_VECTOR;
        state_next = ST_RUN;
      end

      ST_RUN: begin
        opcode  = pmem_data;
        ir_next = pmem_data;
        if (hold) begin
          // The fetch of pc1 here is discarded; SECOND refetches from target.
          target_next = stack_read ? ret_data : rel_target;
          pmem_addr   = pc1;
          state_next  = ST_SECOND;
        end else if (branch_taken) begin
          pmem_addr = rel_target;
          pc_next   = rel_target;
        end else if (skip) begin
          // Fetch past the skipped word now so it lands right after SKIP.
          pmem_addr  = pc1 + ONE;
          pc_next    = pc1;
          state_next = ST_SKIP;
        end else begin
          pmem_addr = pc1;
          pc_next   = pc1;
        end
      end

      ST_SECOND: begin
        opcode     = ir;
        cycle      = 1'b1;
        pmem_addr  = target;
        pc_next    = target;
        state_next = ST_RUN;
      end

      ST_SKIP: begin
        pmem_addr  = pc1;
        pc_next    = pc1;
        state_next = ST_RUN;
      end

      default: begin
        state_next = ST_BOOT;
      end
    endcase
  end

  // State registers; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_BOOT;
      pc     <= RESET_VECTOR;
      ir     <= 16'h0000;
      target <= RESET_VECTOR;
    end else begin
      state  <= state_next;
      pc     <= pc_next;
      ir     <= ir_next;
      target <= target_next;
    end
  end

endmodule

// File: tb/tb_avr_cpu_fetch.sv
// tb_avr_cpu_fetch: scoreboard bench for avr_cpu_fetch. Each stimulus cycle
// pushes the outputs the fetch unit should show for it; they are popped and
// compared mid-cycle against a synchronous program memory model.
module tb_avr_cpu_fetch;

  localparam int PW = 12;

  logic          clk;
  logic          rst_n;
  logic [PW-1:0] pmem_addr;
  logic [15:0]   pmem_data;
  logic [15:0]   opcode;
  logic          cycle;
  logic [PW-1:0] pc;
  logic          hold;
  logic [15:0]   pc_update;
  logic          stack_read;
  logic          stack_write;
  logic [PW-1:0] ret_addr;
  logic [PW-1:0] ret_data;
  logic          branch_taken;
  logic          skip;

  typedef struct {
    string         tag;
    logic [15:0]   opcode;
    logic          cycle;
    logic [PW-1:0] pc;
    logic [PW-1:0] addr;
  } exp_t;

  exp_t        scoreboard[$];
  int          testsRun;
  int          testsFailed;
  logic [15:0] mem [0:(1<<PW)-1];

  avr_cpu_fetch #(.PC_WIDTH(PW), .RESET_VECTOR(12'h000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pmem_addr    (pmem_addr),
    .pmem_data    (pmem_data),
    .opcode       (opcode),
    .cycle        (cycle),
    .pc           (pc),
    .hold         (hold),
    .pc_update    (pc_update),
    .stack_read   (stack_read),
    .stack_write  (stack_write),
    .ret_addr     (ret_addr),
    .ret_data     (ret_data),
    .branch_taken (branch_taken),
    .skip         (skip)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous program memory: data valid the cycle after the address.
  always @(posedge clk) pmem_data <= mem[pmem_addr];

  // Contents of program word a: LDI at 0, NOP at 1, otherwise 0x1000|a.
  function automatic logic [15:0] word(input logic [PW-1:0] a);
    if (a == 12'h000) return 16'hE0A5;
    if (a == 12'h001) return 16'h0000;
    return {4'h1, a};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Pop every pending expectation and compare with what the DUT shows now.
  task automatic drainScoreboard();
    exp_t e;
    logic [PW-1:0] r;
    while (scoreboard.size() > 0) begin
      e = scoreboard.pop_front();
      r = e.pc + 12'd1;
      checkOutput({e.tag, ".opcode"}, {16'h0, opcode}, {16'h0, e.opcode});
      checkOutput({e.tag, ".cycle"}, {31'h0, cycle}, {31'h0, e.cycle});
      checkOutput({e.tag, ".pc"}, {20'h0, pc}, {20'h0, e.pc});
      checkOutput({e.tag, ".pmem_addr"}, {20'h0, pmem_addr}, {20'h0, e.addr});
      checkOutput({e.tag, ".ret_addr"}, {20'h0, ret_addr}, {20'h0, r});
    end
  endtask

  // Drive one cycle of decoder/execute inputs, queue what should be seen,
  // then compare at the falling edge and move to just after the next edge.
  task automatic applyStimulus(input string tag, input logic h, input logic br,
                               input logic sk, input logic sr, input logic sw,
                               input logic [15:0] upd, input logic [PW-1:0] rd,
                               input logic [15:0] eOp, input logic eCyc,
                               input logic [PW-1:0] ePc, input logic [PW-1:0] eAddr);
    exp_t e;
    hold         = h;
    branch_taken = br;
    skip         = sk;
    stack_read   = sr;
    stack_write  = sw;
    pc_update    = upd;
    ret_data     = rd;
    e.tag    = tag;
    e.opcode = eOp;
    e.cycle  = eCyc;
    e.pc     = ePc;
    e.addr   = eAddr;
    scoreboard.push_back(e);
    @(negedge clk);
    drainScoreboard();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".opcode"}, {16'h0, opcode}, 32'h0);
    checkOutput({tag, ".cycle"}, {31'h0, cycle}, 32'h0);
    checkOutput({tag, ".pc"}, {20'h0, pc}, 32'h0);
    checkOutput({tag, ".pmem_addr"}, {20'h0, pmem_addr}, 32'h0);
    checkOutput({tag, ".ret_addr"}, {20'h0, ret_addr}, 32'h1);
  endtask

  initial begin
    testsRun     = 0;
    testsFailed  = 0;
    rst_n        = 1'b0;
    hold         = 1'b0;
    branch_taken = 1'b0;
    skip         = 1'b0;
    stack_read   = 1'b0;
    stack_write  = 1'b0;
    pc_update    = 16'h0;
    ret_data     = '0;
    for (int i = 0; i < (1 << PW); i++) mem[i] = word(i[PW-1:0]);

    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst_n = 1'b1;

    // Reset release and straight-line code.
    applyStimulus("boot", 0,0,0,0,0, 16'h0, 12'h0, 16'h0000, 0, 12'h000, 12'h000);
    applyStimulus("ldi",  0,0,0,0,0, 16'h0, 12'h0, 16'hE0A5, 0, 12'h000, 12'h001);
    applyStimulus("pc1",  0,0,0,0,0, 16'h0, 12'h0, 16'h0000, 0, 12'h001, 12'h002);
    for (int a = 2; a < 5; a++)
      applyStimulus("line", 0,0,0,0,0, 16'h0, 12'h0, word(a[PW-1:0]), 0,
                    a[PW-1:0], a[PW-1:0] + 12'd1);

    // RJMP -3 at 5; branch_taken during SECOND must be ignored.
    applyStimulus("rjmp1", 1,0,0,0,0, 16'hFFFD, 12'h0, 16'h1005, 0, 12'h005, 12'h006);
    applyStimulus("rjmp2", 0,1,0,0,0, 16'h0040, 12'h0, 16'h1005, 1, 12'h005, 12'h003);
    // Arrive at 3, take a branch to 0x20.
    applyStimulus("br20",  0,1,0,0,0, 16'h001C, 12'h0, 16'h1003, 0, 12'h003, 12'h020);
    // RET at 0x20 to 0x105.
    applyStimulus("ret1",  1,0,0,1,0, 16'h0, 12'h105, 16'h1020, 0, 12'h020, 12'h021);
    applyStimulus("ret2",  0,0,0,0,0, 16'h0, 12'h000, 16'h1020, 1, 12'h020, 12'h105);
    // At 0x105, branch back to 8.
    applyStimulus("br8",   0,1,0,0,0, 16'hFF02, 12'h0, 16'h1105, 0, 12'h105, 12'h008);
    // Skip at 8; hold during SKIP must be ignored.
    applyStimulus("skip1", 0,0,1,0,0, 16'h0, 12'h0, 16'h1008, 0, 12'h008, 12'h00A);
    applyStimulus("skip2", 1,0,0,0,0, 16'h0, 12'h0, 16'h0000, 0, 12'h009, 12'h00A);
    // Resume at 10, then branch to 0xFFE and wrap.
    applyStimulus("brFFE", 0,1,0,0,0, 16'hFFF3, 12'h0, 16'h100A, 0, 12'h00A, 12'hFFE);
    applyStimulus("wrap1", 0,0,0,0,0, 16'h0, 12'h0, 16'h1FFE, 0, 12'hFFE, 12'hFFF);
    applyStimulus("wrap2", 0,0,0,0,0, 16'h0, 12'h0, 16'h1FFF, 0, 12'hFFF, 12'h000);
    applyStimulus("wrap3", 0,0,0,0,0, 16'h0, 12'h0, 16'hE0A5, 0, 12'h000, 12'h001);
    applyStimulus("brneg", 0,1,0,0,0, 16'hFFFC, 12'h0, 16'h0000, 0, 12'h001, 12'hFFE);
    // RCALL +0x10 at 0xFFE with skip alongside: hold wins, target wraps to 0x00F.
    applyStimulus("rcall1", 1,0,1,0,1, 16'h0010, 12'h0, 16'h1FFE, 0, 12'hFFE, 12'hFFF);

    // SECOND of the RCALL, then reset mid-cycle.
    hold = 1'b0; skip = 1'b0; stack_write = 1'b0; pc_update = 16'h0;
    begin
      exp_t e;
      e.tag = "rcall2"; e.opcode = 16'h1FFE; e.cycle = 1'b1;
      e.pc = 12'hFFE; e.addr = 12'h00F;
      scoreboard.push_back(e);
    end
    @(negedge clk);
    drainScoreboard();
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    applyStimulus("reboot", 0,0,0,0,0, 16'h0, 12'h0, 16'h0000, 0, 12'h000, 12'h000);
    applyStimulus("restart", 0,0,0,0,0, 16'h0, 12'h0, 16'hE0A5, 0, 12'h000, 12'h001);
    applyStimulus("restart1", 0,0,0,0,0, 16'h0, 12'h0, 16'h0000, 0, 12'h001, 12'h002);

    checkOutput("sb_empty", scoreboard.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
